// File: rtl/fetch_unit_pkg.sv
// Shared widths, entry layout and PC alignment helper for the fetch stage.
package fetch_unit_pkg;

   localparam int XLEN          = 32;
   localparam int INST_W        = 32;
   localparam int FETCH_ENTRY_W = 64;
   localparam logic [XLEN-1:0] FETCH_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & FETCH_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, redirect and datapath handshake.
// Carries perf_fetched/perf_dropped only when FETCH_PERF_CNT_EN is defined.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [XLEN-1:0]   imem_req_addr;
   logic              imem_rsp_valid;
   logic [INST_W-1:0] imem_rsp_data;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [INST_W-1:0] inst_out;
   logic [XLEN-1:0]   inst_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]       perf_fetched;
   logic [31:0]       perf_dropped;
`endif

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
`ifdef FETCH_PERF_CNT_EN
      output perf_fetched, perf_dropped,
`endif
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
`ifdef FETCH_PERF_CNT_EN
      input  perf_fetched, perf_dropped,
`endif
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; flush wins over push/pop, simultaneous push/pop both honoured.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // storage needs no reset: count gates visibility of every slot
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited imem issue, in-order response queue, redirect flush.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit import fetch_unit_pkg::*; #(
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int OW = $clog2(MAX_OUTSTANDING+1);
   localparam int SW = CW + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   drop_cnt;
   logic [CW-1:0]   count;
   logic            fifo_empty;
   logic            fifo_full;
   logic            fifo_push;
   logic            fifo_pop;
   logic            credit_ok;
   logic            req_fire;
   logic            rsp_drop;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;

   // every issued request already owns a queue slot, so responses never stall
   assign credit_ok = (outstanding < OW'(MAX_OUTSTANDING)) &&
                      ((SW'(outstanding) + SW'(count)) < SW'(DEPTH));

   assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit_ok;
   assign bus.imem_req_addr  = fetch_pc;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

   assign rsp_drop   = bus.imem_rsp_valid && ((drop_cnt != '0) || bus.redirect_valid);
   assign fifo_push  = bus.imem_rsp_valid && !rsp_drop;
   assign fifo_pop   = bus.inst_valid && bus.inst_ready;
   assign push_entry = '{pc: rsp_pc, inst: bus.imem_rsp_data};

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FETCH_ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .flush     (bus.redirect_valid),
      .head_data (head_entry),
      .count     (count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign bus.inst_valid = !fifo_empty;
   assign bus.inst_out   = head_entry.inst;
   assign bus.inst_pc    = head_entry.pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + OW'(req_fire) - OW'(bus.imem_rsp_valid);
         if (bus.redirect_valid) begin
            fetch_pc <= align_pc(bus.redirect_pc);
            rsp_pc   <= align_pc(bus.redirect_pc);
            drop_cnt <= outstanding - OW'(bus.imem_rsp_valid);
         end else begin
            if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
            if (fifo_push) rsp_pc   <= rsp_pc + 32'd4;
            if (rsp_drop)  drop_cnt <= drop_cnt - OW'(1);
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_dropped;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         perf_fetched <= perf_fetched + 32'(fifo_push);
         perf_dropped <= perf_dropped + 32'(rsp_drop) +
                         (bus.redirect_valid ? 32'(count) : 32'd0);
      end
   end

   assign bus.perf_fetched = perf_fetched;
   assign bus.perf_dropped = perf_dropped;
`endif

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));
   a_drop_le_out: assert property (@(posedge clk) disable iff (rst) drop_cnt <= outstanding);
   a_out_le_max:  assert property (@(posedge clk) disable iff (rst) outstanding <= OW'(MAX_OUTSTANDING));
   a_credit:      assert property (@(posedge clk) disable iff (rst)
                                   (SW'(outstanding) + SW'(count)) <= SW'(DEPTH));

endmodule
